// File: rtl/btn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : btn_pkg                                                        |
// | Purpose  : Shared types and constants for the push-button conditioner.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int BTN_RUN   = 0;
    localparam int BTN_CLRLD = 1;

    // A single-cycle debounce still needs a 1-bit counter to keep the port legal.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_debounce_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : btn_debounce_fsm                                               |
// | Purpose  : One button: synchronizer, debounce FSM, level + edge pulses.  |
// |            BTN_DEBOUNCE_BYPASS_EN removes the debounce counter/waits.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module btn_debounce_fsm
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Btn_raw,
    output logic Btn_level,
    output logic Btn_rise,
    output logic Btn_fall
);

    logic                   w_pressed;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;

    // Normalise polarity before the first flop so reset "0" means not pressed.
    assign w_pressed = (ACTIVE_LOW != 0) ? ~Btn_raw : Btn_raw;
    assign w_sync    = r_sync[SYNC_STAGES-1];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_pressed};
        end
    end

`ifdef BTN_DEBOUNCE_BYPASS_EN

    logic r_sync_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sync_d  <= 1'b0;
            Btn_level <= 1'b0;
            Btn_rise  <= 1'b0;
            Btn_fall  <= 1'b0;
        end else begin
            r_sync_d  <= w_sync;
            Btn_level <= r_sync_d;
            Btn_rise  <= r_sync_d & ~Btn_level;
            Btn_fall  <= ~r_sync_d & Btn_level;
        end
    end

`else

    localparam int                 c_cnt_w   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    btn_state_t         r_state;
    btn_state_t         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_level_nxt;
    logic               w_rise_nxt;
    logic               w_fall_nxt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            Btn_level <= 1'b0;
            Btn_rise  <= 1'b0;
            Btn_fall  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            Btn_level <= w_level_nxt;
            Btn_rise  <= w_rise_nxt;
            Btn_fall  <= w_fall_nxt;
        end
    end

    // Any disagreement during a wait sends the FSM back and restarts the count.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = Btn_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sync) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_sync) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_max) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            HELD: begin
                if (!w_sync) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (w_sync) begin
                    w_state_nxt = HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_cnt_max) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

`endif

endmodule : btn_debounce_fsm
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : btn_conditioner                                                |
// | Purpose  : Synchronizes and debounces NUM_BTN raw push-button pins.      |
// |            BTN_DEBOUNCE_BYPASS_EN selects the simulation-only bypass.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NUM_BTN-1:0] Btn_raw,
    output logic [NUM_BTN-1:0] Btn_level,
    output logic [NUM_BTN-1:0] Btn_rise,
    output logic [NUM_BTN-1:0] Btn_fall
);

    generate
        for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
            btn_debounce_fsm #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .ACTIVE_LOW      (ACTIVE_LOW)
            ) u_btn (
                .Clk       (Clk),
                .Reset     (Reset),
                .Btn_raw   (Btn_raw[g]),
                .Btn_level (Btn_level[g]),
                .Btn_rise  (Btn_rise[g]),
                .Btn_fall  (Btn_fall[g])
            );
        end
    endgenerate

endmodule : btn_conditioner
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_btn_conditioner                                             |
// | Purpose  : Self-checking bench for btn_conditioner (2 stages, 4 cycles). |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_btn_conditioner;
    import btn_pkg::*;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
`ifdef BTN_DEBOUNCE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    // Reference behaviour: a change is accepted once ACC consecutive samples
    // disagree with the current level; outputs appear PIPE edges after the
    // accepting sample.
    localparam int ACC     = BYPASS ? 1 : DEB + 1;
    localparam int PIPE    = BYPASS ? SYNC + 1 : SYNC;
    localparam int EXP_LAT = BYPASS ? 3 : 6;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [1:0] Btn_raw = 2'b11;
    logic [1:0] Btn_level, Btn_rise, Btn_fall;

    btn_conditioner #(
        .NUM_BTN         (2),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .ACTIVE_LOW      (1)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Btn_raw   (Btn_raw),
        .Btn_level (Btn_level),
        .Btn_rise  (Btn_rise),
        .Btn_fall  (Btn_fall)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [1:0] level;
        logic [1:0] rise;
        logic [1:0] fall;
    } exp_t;

    typedef struct {
        string      name;
        logic [1:0] mask;
        int         press_n;
        int         release_n;
        logic [1:0] exp_deb;
        logic [1:0] exp_byp;
    } vec_t;

    exp_t       sb_q[$];
    logic [1:0] m_level;
    int         m_run[2];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] lvl_s, rise_s, fall_s;
    vec_t       vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_push(input logic [1:0] raw);
        exp_t e;
        logic p;
        e = '0;
        for (int b = 0; b < 2; b++) begin
            p = ~raw[b];
            if (p != m_level[b]) m_run[b]++;
            else m_run[b] = 0;
            if (m_run[b] == ACC) begin
                m_level[b] = p;
                m_run[b]   = 0;
                if (p) e.rise[b] = 1'b1;
                else   e.fall[b] = 1'b1;
            end
        end
        e.level = m_level;
        sb_q.push_back(e);
    endtask

    task automatic prefill();
        m_level  = 2'b00;
        m_run[0] = 0;
        m_run[1] = 0;
        sb_q.delete();
        repeat (PIPE) sb_q.push_back('0);
    endtask

    // Called at a negedge; drives one sample, checks the following edge, returns at the next negedge.
    task automatic drive(input logic [1:0] raw);
        exp_t e;
        Btn_raw = raw;
        model_push(raw);
        @(posedge Clk);
        #1;
        lvl_s  = Btn_level;
        rise_s = Btn_rise;
        fall_s = Btn_fall;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("sb", {lvl_s, rise_s, fall_s}, e);
        end
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        check("reset_async", {Btn_level, Btn_rise, Btn_fall}, 32'd0);
        @(posedge Clk);
        #1;
        check("reset_hold", {Btn_level, Btn_rise, Btn_fall}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        prefill();
    endtask

    initial begin
        int         nr[2];
        int         nf[2];
        int         fr0, fr1, ff0, r_after;
        logic [1:0] exp_m;

        vecs[0] = '{"run_press",   2'b01, 8, 10, 2'b01, 2'b01};
        vecs[1] = '{"run_glitch3", 2'b01, 3, 10, 2'b00, 2'b01};
        vecs[2] = '{"clr_press",   2'b10, 8, 10, 2'b10, 2'b10};
        vecs[3] = '{"both_press",  2'b11, 8, 10, 2'b11, 2'b11};
        vecs[4] = '{"run_min5",    2'b01, 5, 10, 2'b01, 2'b01};
        vecs[5] = '{"run_glitch4", 2'b01, 4, 10, 2'b00, 2'b01};

        repeat (3) @(posedge Clk);
        #1;
        check("reset_state", {Btn_level, Btn_rise, Btn_fall}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        prefill();

        for (int v = 0; v < 6; v++) begin
            nr[0] = 0; nr[1] = 0; nf[0] = 0; nf[1] = 0;
            for (int i = 0; i < vecs[v].press_n + vecs[v].release_n; i++) begin
                drive((i < vecs[v].press_n) ? ~vecs[v].mask : 2'b11);
                for (int b = 0; b < 2; b++) begin
                    nr[b] += int'(rise_s[b]);
                    nf[b] += int'(fall_s[b]);
                end
            end
            exp_m = BYPASS ? vecs[v].exp_byp : vecs[v].exp_deb;
            for (int b = 0; b < 2; b++) begin
                check({vecs[v].name, "_rises"}, nr[b], {31'd0, exp_m[b]});
                check({vecs[v].name, "_falls"}, nf[b], {31'd0, exp_m[b]});
            end
        end

        // Press latency, single-cycle rise, release latency.
        fr0 = -1; r_after = -1;
        for (int i = 0; i < 12; i++) begin
            drive(2'b10);
            if (fr0 >= 0 && i == fr0 + 1) r_after = int'(rise_s[BTN_RUN]);
            if (rise_s[BTN_RUN] && fr0 < 0) fr0 = i;
        end
        check("press_latency", fr0, EXP_LAT);
        check("rise_one_cycle", r_after, 0);
        check("press_level", {31'd0, lvl_s[BTN_RUN]}, 32'd1);
        ff0 = -1;
        for (int i = 0; i < 12; i++) begin
            drive(2'b11);
            if (fall_s[BTN_RUN] && ff0 < 0) ff0 = i;
        end
        check("release_latency", ff0, EXP_LAT);
        check("release_level", {31'd0, lvl_s[BTN_RUN]}, 32'd0);

        // Short release bounce while held.
        repeat (8) drive(2'b10);
        nf[0] = 0;
        repeat (2) begin drive(2'b11); nf[0] += int'(fall_s[BTN_RUN]); end
        repeat (8) begin drive(2'b10); nf[0] += int'(fall_s[BTN_RUN]); end
        check("bounce_falls", nf[0], BYPASS ? 1 : 0);
        check("bounce_level", {31'd0, lvl_s[BTN_RUN]}, 32'd1);
        repeat (12) drive(2'b11);

        // Reset with ClearA_LoadB held and Run mid-debounce; both restart as new presses.
        repeat (8) drive(2'b01);
        repeat (3) drive(2'b00);
        do_reset();
        fr0 = -1; fr1 = -1;
        for (int i = 0; i < 12; i++) begin
            drive(2'b00);
            if (rise_s[BTN_RUN] && fr0 < 0) fr0 = i;
            if (rise_s[BTN_CLRLD] && fr1 < 0) fr1 = i;
        end
        check("rerun_latency_run", fr0, EXP_LAT);
        check("rerun_latency_clrld", fr1, EXP_LAT);
        repeat (12) drive(2'b11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_btn_conditioner
`default_nettype wire
